// File: rtl/rx_byte_fifo_if.sv
// Byte stream handshake between the serial receiver side, the byte FIFO and its consumer.
// The producer/consumer side takes the master modport. The FIFO takes the slave modport.
interface rx_byte_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] data_in;
    logic              received;
    logic              rd_en;
    logic              clear_ovf;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output data_in, received, rd_en, clear_ovf,
        input  data_out, empty, full, count, overflow
    );

    modport slave (
        input  data_in, received, rd_en, clear_ovf,
        output data_out, empty, full, count, overflow
    );
endinterface

// File: rtl/rx_byte_fifo_rise_detect.sv
// 1-bit rising-edge detector with async active-low reset.
// The delay register resets to 1, so a level that is already high at reset release gives no pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b1;
        else      d_q <= d;
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/rx_byte_fifo.sv
// Show-ahead receive byte FIFO fed by the serial receiver's data/received pair.
// The full and empty flags are registered together with count. A write into a full FIFO with no read is dropped, and the sticky overflow flag is set.
module rx_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    rx_byte_fifo_if.slave  bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt_q, cnt_nxt;
    logic              empty_q, full_q, ovf_q;
    logic              wr, wr_ok, rd_ok, drop;

    rise_detect u_rx_rise (
        .clk   (clk),
        .rst   (rst),
        .d     (bus.received),
        .pulse (wr)
    );

    // When the FIFO is full it is never empty, so rd_en alone guarantees a free slot this cycle.
    assign rd_ok = bus.rd_en & ~empty_q;
    assign wr_ok = wr & (~full_q | bus.rd_en);
    assign drop  = wr & full_q & ~bus.rd_en;

    always_comb begin
        cnt_nxt = cnt_q;
        if (wr_ok && !rd_ok)      cnt_nxt = cnt_q + 1'b1;
        else if (rd_ok && !wr_ok) cnt_nxt = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            cnt_q   <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == (ADDR_W+1)'(DEPTH));
            if (drop)               ovf_q <= 1'b1;
            else if (bus.clear_ovf) ovf_q <= 1'b0;
        end
    end

    // The head is read straight from storage, so it follows rd_ptr on the same edge.
    assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = cnt_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: reset, edge-strobed writes, show-ahead reads, full/overflow corners, pointer wrap, and async reset.
module tb_rx_byte_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    byte  q[$];

    rx_byte_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    rx_byte_fifo #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.data_in  = b;
        bus.received = 1'b1;
        tick();
        bus.received = 1'b0;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, bus.data_out}, {24'd0, exp});
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.data_in   = '0;
        bus.received  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.clear_ovf = 1'b0;

        // reset state
        repeat (2) tick();
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_count", {27'd0, bus.count}, 32'd0);
        check("rst_dout", {24'd0, bus.data_out}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        // received held high across reset release
        bus.received = 1'b1;
        tick();
        #2 rst = 1'b1;
        repeat (3) tick();
        check("held_rx_count", {27'd0, bus.count}, 32'd0);
        bus.received = 1'b0;
        tick();

        // long received level gives one write
        bus.data_in  = 8'h41;
        bus.received = 1'b1;
        tick();
        check("a_count", {27'd0, bus.count}, 32'd1);
        check("a_dout", {24'd0, bus.data_out}, 32'h41);
        repeat (3) tick();
        check("a_count_held", {27'd0, bus.count}, 32'd1);
        bus.received = 1'b0;
        tick();
        pop_check("a_pop", 8'h41);
        check("a_empty", {31'd0, bus.empty}, 32'd1);
        check("a_dout0", {24'd0, bus.data_out}, 32'd0);

        // rd_en while empty is ignored
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("rd_empty_count", {27'd0, bus.count}, 32'd0);
        check("rd_empty_ovf", {31'd0, bus.overflow}, 32'd0);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_full", {31'd0, bus.full}, 32'd1);
        check("fill_count", {27'd0, bus.count}, 32'd16);
        push(8'hAA);
        check("drop_ovf", {31'd0, bus.overflow}, 32'd1);
        check("drop_count", {27'd0, bus.count}, 32'd16);
        for (int i = 0; i < 16; i++) pop_check($sformatf("drain_%0d", i), 8'(i));
        check("drain_empty", {31'd0, bus.empty}, 32'd1);
        check("drain_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        check("clr_ovf", {31'd0, bus.overflow}, 32'd0);

        // write and read together while full
        for (int i = 0; i < 16; i++) push(8'(i));
        bus.data_in  = 8'h55;
        bus.received = 1'b1;
        bus.rd_en    = 1'b1;
        tick();
        bus.received = 1'b0;
        bus.rd_en    = 1'b0;
        check("fwr_dout", {24'd0, bus.data_out}, 32'h01);
        check("fwr_count", {27'd0, bus.count}, 32'd16);
        check("fwr_full", {31'd0, bus.full}, 32'd1);
        check("fwr_ovf", {31'd0, bus.overflow}, 32'd0);
        tick();
        for (int i = 1; i < 16; i++) pop_check($sformatf("fwr_drain_%0d", i), 8'(i));
        pop_check("fwr_last", 8'h55);
        check("fwr_empty", {31'd0, bus.empty}, 32'd1);

        // interleaved traffic across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h80 + i));
            q.push_back(byte'(8'h80 + i));
            check($sformatf("wrap_occ_%0d", i), {31'd0, (bus.count > 5'd3)}, 32'd0);
            if (i >= 2) pop_check($sformatf("wrap_rd_%0d", i), q.pop_front());
        end
        while (q.size() > 0) pop_check("wrap_tail", q.pop_front());
        check("wrap_empty", {31'd0, bus.empty}, 32'd1);

        // clear_ovf loses to a simultaneous drop
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'hEE);
        check("ovf2_set", {31'd0, bus.overflow}, 32'd1);
        bus.data_in   = 8'hEF;
        bus.received  = 1'b1;
        bus.clear_ovf = 1'b1;
        tick();
        bus.received = 1'b0;
        check("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
        check("ovf_set_count", {27'd0, bus.count}, 32'd16);
        tick();
        bus.clear_ovf = 1'b0;
        check("ovf_clear_alone", {31'd0, bus.overflow}, 32'd0);

        // async reset mid-stream at count 5 with overflow set
        push(8'hEE);
        for (int i = 0; i < 11; i++) pop_check($sformatf("pre_rst_%0d", i), 8'(8'h20 + i));
        check("pre_rst_count", {27'd0, bus.count}, 32'd5);
        check("pre_rst_ovf", {31'd0, bus.overflow}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_count", {27'd0, bus.count}, 32'd0);
        check("arst_empty", {31'd0, bus.empty}, 32'd1);
        check("arst_full", {31'd0, bus.full}, 32'd0);
        check("arst_dout", {24'd0, bus.data_out}, 32'd0);
        check("arst_ovf", {31'd0, bus.overflow}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        push(8'h77);
        check("post_rst_dout", {24'd0, bus.data_out}, 32'h77);
        check("post_rst_count", {27'd0, bus.count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
